// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH product over WIDTH cycles.
// Returns the low WIDTH product bits plus a flag set when the product does not sign-fit.
module booth_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned HW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [HW-1:0]    m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [HW-1:0]    hi_next;
    logic [PW-1:0]    p_step;
    logic [PW-1:0]    p_shift;

    // One Booth step: conditional add/subtract on the 33-bit accumulator, then
    // an arithmetic right shift of the whole product register.
    always_comb begin
        hi_next = p_q[PW-1 -: HW];
        unique case (p_q[1:0])
            2'b01:   hi_next = p_q[PW-1 -: HW] + m_q;
            2'b10:   hi_next = p_q[PW-1 -: HW] - m_q;
            default: hi_next = p_q[PW-1 -: HW];
        endcase
        p_step  = {hi_next, p_q[WIDTH:0]};
        p_shift = {p_step[PW-1], p_step[PW-1:1]};
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;

        if (ctrl_MULT) begin
            // A start in any state, including mid-run, reloads and restarts.
            m_d     = {data_operandA[WIDTH-1], data_operandA};
            p_d     = {{HW{1'b0}}, data_operandB, 1'b0};
            cnt_d   = '0;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    p_d = p_shift;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_result    = p_q[WIDTH:1];
    // Upper product bits plus the result sign bit must all agree to fit.
    assign data_exception = ~((&p_q[2*WIDTH:WIDTH]) | ~(|p_q[2*WIDTH:WIDTH]));
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StRun);

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier: products, latency, abort, back-to-back, reset.
module tb_booth_multiplier;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    booth_multiplier #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands at a falling edge; returns at the falling edge after the load edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
    endtask

    // Called right after start_op; waits for RDY with a bounded cycle budget.
    task automatic wait_rdy(input string tag, input logic [31:0] exp_r, input logic exp_e);
        int lat;
        lat = 0;
        while (!data_resultRDY && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " result"}, 64'(data_result), 64'(exp_r));
        check({tag, " exception"}, 64'(data_exception), 64'(exp_e));
    endtask

    task automatic run_and_hold(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_r, input logic exp_e);
        start_op(a, b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_rdy(tag, exp_r, exp_e);
        @(negedge clock);
        check({tag, " rdy drop"}, 64'(data_resultRDY), 64'd0);
        check({tag, " idle busy"}, 64'(busy), 64'd0);
        check({tag, " held result"}, 64'(data_result), 64'(exp_r));
        check({tag, " held exception"}, 64'(data_exception), 64'(exp_e));
    endtask

    initial begin
        int          pulses;
        int          first;
        logic [31:0] r_seen;
        logic        e_seen;

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset result", 64'(data_result), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_and_hold("6x7", 32'd6, 32'd7, 32'h0000002A, 1'b0);
        run_and_hold("-3x5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0);
        run_and_hold("min x -1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_and_hold("2^16 sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_and_hold("max sq", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        run_and_hold("max x 1", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
        run_and_hold("min x 1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);

        // Back-to-back: new start during the DONE cycle.
        start_op(32'd9, 32'hFFFFFFFF);
        wait_rdy("b2b first", 32'hFFFFFFF7, 1'b0);
        start_op(32'h0000FFFF, 32'h0000FFFF);
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b rdy low", 64'(data_resultRDY), 64'd0);
        wait_rdy("b2b second", 32'hFFFE0001, 1'b1);
        @(negedge clock);

        // Abort at iteration 10 with a fresh operand pair.
        start_op(32'd3, 32'd4);
        repeat (9) @(negedge clock);
        start_op(32'hFFFFFFFE, 32'hFFFFFFF8);
        check("abort busy", 64'(busy), 64'd1);
        pulses = 0;
        first  = -1;
        r_seen = '0;
        e_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                if (first < 0) begin
                    first  = i;
                    r_seen = data_result;
                    e_seen = data_exception;
                end
            end
        end
        check("abort rdy pulses", 64'(pulses), 64'd1);
        check("abort latency", 64'(first), 64'd32);
        check("abort result", 64'(r_seen), 64'h10);
        check("abort exception", 64'(e_seen), 64'd0);

        // Asynchronous reset mid-run at iteration 20.
        start_op(32'h12345678, 32'h0000FFFF);
        repeat (20) @(negedge clock);
        check("pre-reset busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset rdy", 64'(data_resultRDY), 64'd0);
        check("async reset result", 64'(data_result), 64'd0);
        check("async reset exception", 64'(data_exception), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post-reset idle result", 64'(data_result), 64'd0);
        run_and_hold("1x1", 32'd1, 32'd1, 32'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
